// File: rtl/line_burst_gen_pkg.sv
// line_burst_gen_pkg: shared cache constants and burst FSM state type.
package line_burst_gen_pkg;
    localparam int LINE_WORDS = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/line_burst_gen_if.sv
// line_burst_gen_if: start request and memory word-request signals of the burst generator.
interface line_burst_gen_if #(
    parameter int OFFW = 2
);
    logic            start_i;
    logic [9:0]      base_addr_i;
    logic [OFFW-1:0] crit_word_i;
    logic            wr_i;
    logic            mem_ready_i;
    logic            mem_req_o;
    logic [9:0]      mem_addr_o;
    logic            mem_we_o;
    logic [OFFW-1:0] word_idx_o;
    logic            busy_o;
    logic            done_o;
    modport master (
        input  start_i, base_addr_i, crit_word_i, wr_i, mem_ready_i,
        output mem_req_o, mem_addr_o, mem_we_o, word_idx_o, busy_o, done_o
    );
    modport slave (
        output start_i, base_addr_i, crit_word_i, wr_i, mem_ready_i,
        input  mem_req_o, mem_addr_o, mem_we_o, word_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/line_burst_gen_adder.sv
// adder_10bit: 10-bit word-address adder, carry discarded.
module adder_10bit (
    input  logic [9:0] a_i,
    input  logic [9:0] b_i,
    output logic [9:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

// File: rtl/line_burst_gen.sv
// line_burst_gen: critical-word-first cache line burst sequencer.
module line_burst_gen
    import line_burst_gen_pkg::*;
#(
    parameter int WORDS = LINE_WORDS,
    parameter int OFFW  = $clog2(WORDS)
) (
    input logic clk_i,
    input logic rst_i,
    line_burst_gen_if.master bus
);
    localparam logic [9:0] ALIGN = ~10'(WORDS - 1);
    state_e          state_q, state_d;
    logic [OFFW-1:0] cnt_q, cnt_d, crit_q, crit_d, idx;
    logic [9:0]      base_q, base_d, sum;
    logic            wr_q, wr_d, in_req;
    assign in_req = state_q == ST_REQ;
    assign idx    = crit_q + cnt_q;
    adder_10bit u_add (
        .a_i  (base_q),
        .b_i  ({{(10 - OFFW){1'b0}}, idx}),
        .sum_o(sum)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        crit_d  = crit_q;
        wr_d    = wr_q;
        if (state_q == ST_IDLE && bus.start_i) begin
            state_d = ST_REQ;
            cnt_d   = '0;
            base_d  = bus.base_addr_i & ALIGN;
            crit_d  = bus.crit_word_i;
            wr_d    = bus.wr_i;
        end else if (in_req && bus.mem_ready_i) begin
            cnt_d   = cnt_q + OFFW'(1);
            state_d = cnt_q == OFFW'(WORDS - 1) ? ST_DONE : ST_REQ;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            crit_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            crit_q  <= crit_d;
            wr_q    <= wr_d;
        end
    end
    // outside REQ the address/index buses park on the latched line base and critical word
    assign bus.mem_req_o  = in_req;
    assign bus.mem_we_o   = in_req & wr_q;
    assign bus.word_idx_o = in_req ? idx : crit_q;
    assign bus.mem_addr_o = in_req ? sum : base_q;
    assign bus.busy_o     = state_q != ST_IDLE;
    assign bus.done_o     = state_q == ST_DONE;
endmodule

// File: tb/tb_line_burst_gen.sv
// tb_line_burst_gen: randomized and directed burst checks against a line-wrap address model.
module tb_line_burst_gen;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    line_burst_gen_if #(.OFFW(2)) bus ();
    line_burst_gen #(.WORDS(W), .OFFW(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [9:0] model_addr(input logic [9:0] base, input int crit, input int k);
        return 10'((((int'(base) / W) * W) + ((crit + k) % W)) % 1024);
    endfunction

    task automatic run_burst(input logic [9:0] base, input logic [1:0] crit, input logic wr,
                             input int mode, input bit glitch, input bit done_start);
        int k, cyc;
        logic rdy;
        logic [9:0] ea;
        logic [1:0] ei;
        bus.start_i = 1'b1;
        bus.base_addr_i = base;
        bus.crit_word_i = crit;
        bus.wr_i = wr;
        bus.mem_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.base_addr_i = 10'($urandom);
        bus.crit_word_i = 2'($urandom);
        bus.wr_i = ~wr;
        k = 0;
        cyc = 0;
        while (k < W && cyc < 200) begin
            ei = 2'((int'(crit) + k) % W);
            ea = model_addr(base, int'(crit), k);
            checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL beat_req k=%0d got %b want 1", k, bus.mem_req_o); end
            checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL beat_busy k=%0d got %b want 1", k, bus.busy_o); end
            checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL beat_done k=%0d got %b want 0", k, bus.done_o); end
            checks++; if (bus.mem_addr_o !== ea) begin errors++; $display("FAIL beat_addr k=%0d cyc=%0d got %h want %h", k, cyc, bus.mem_addr_o, ea); end
            checks++; if (bus.word_idx_o !== ei) begin errors++; $display("FAIL beat_idx k=%0d got %0d want %0d", k, bus.word_idx_o, ei); end
            checks++; if (bus.mem_we_o !== wr) begin errors++; $display("FAIL beat_we k=%0d got %b want %b", k, bus.mem_we_o, wr); end
            rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : mode == 3 ? (cyc >= 10) : 1'($urandom_range(0, 1));
            bus.mem_ready_i = rdy;
            bus.start_i = glitch && cyc == 1;
            if (glitch && cyc == 1) bus.base_addr_i = 10'h200;
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        bus.start_i = 1'b0;
        checks++; if (k != W) begin errors++; $display("FAIL burst_timeout beats got %0d want %0d", k, W); end
        if (mode == 0 || mode == 3) begin
            checks++; if (cyc != (mode == 0 ? W : W + 10)) begin errors++; $display("FAIL burst_len got %0d want %0d", cyc, mode == 0 ? W : W + 10); end
        end
        checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL done_pulse got %b want 1", bus.done_o); end
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL done_req got %b want 0", bus.mem_req_o); end
        checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL done_we got %b want 0", bus.mem_we_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL done_busy got %b want 1", bus.busy_o); end
        checks++; if (bus.mem_addr_o !== model_addr(base, 0, 0)) begin errors++; $display("FAIL done_addr got %h want %h", bus.mem_addr_o, model_addr(base, 0, 0)); end
        bus.start_i = done_start;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", bus.done_o); end
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", bus.mem_req_o); end
        if (done_start) begin
            @(negedge clk);
            checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL done_start_ignored busy got %b want 0", bus.busy_o); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.base_addr_i = 10'h155;
        bus.crit_word_i = 2'd3;
        bus.wr_i = 1'b1;
        bus.mem_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.mem_req_o); end
        checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.mem_we_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        checks++; if (bus.mem_addr_o !== 10'h000) begin errors++; $display("FAIL reset_addr got %h want 000", bus.mem_addr_o); end
        checks++; if (bus.word_idx_o !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", bus.word_idx_o); end
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL idle_ready_no_effect busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_refill();
        run_burst(10'h104, 2'd2, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_writeback_stall();
        run_burst(10'h3FC, 2'd0, 1'b1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_unaligned();
        run_burst(10'h0AB, 2'd3, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_burst(10'h150, 2'd1, 1'b1, 0, 1'b1, 1'b1);
    endtask

    task automatic test_long_stall();
        run_burst(10'h2E0, 2'd1, 1'b0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.start_i = 1'b1;
        bus.base_addr_i = 10'h314;
        bus.crit_word_i = 2'd1;
        bus.wr_i = 1'b1;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_addr_o !== model_addr(10'h314, 1, 2)) begin errors++; $display("FAIL mid_third_addr got %h want %h", bus.mem_addr_o, model_addr(10'h314, 1, 2)); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", bus.mem_req_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.mem_addr_o !== 10'h000) begin errors++; $display("FAIL mid_rst_addr got %h want 000", bus.mem_addr_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL mid_rst_done cyc=%0d got %b want 0", i, bus.done_o); end
            @(negedge clk);
        end
        run_burst(10'h314, 2'd1, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_priority();
        rst = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_over_start busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_burst(10'($urandom), 2'($urandom), 1'($urandom), 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.base_addr_i = '0;
        bus.crit_word_i = '0;
        bus.wr_i = 1'b0;
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_refill();
        test_writeback_stall();
        test_unaligned();
        test_start_ignored();
        test_long_stall();
        test_reset_mid();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
